alu_seq: RTL and testbench

Parametrised, registered ALU with an integrated register file, operand-select mux, start/done handshake and condition codes. Sits between the instruction decoder and the data bus. Executes one operation per request: read operands, compute, write back to a destination register, then drive the result onto ANSWER when gated. Extends the combinational ALU/REGBANK pairing with configurable width, register count and operation set, plus an optional iterative multiplier.

---
 rtl/alu_seq.sv | 213 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with an integrated register file, an operand-2 select mux,
// a start/done handshake and {N,Z,P} condition codes.
//
// One operation per request: operands are latched on accept (IDLE), the result is
// computed in EXEC (or iteratively in MULT), then written to R[dest] and RESULT.
//
// Optional feature macro: ALU_SEQ_MUL_EN
//   defined   - aluk=111 runs a shift-add multiply, one bit per cycle, for WIDTH cycles.
//   undefined - no multiplier or MULT state is built. aluk=111 completes in EXEC and
//               pulses done, with no register write and no RESULT/NZP update.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   start / ready   request (accepted only while ready) / high in IDLE
//   aluk            operation code
//   sr2select       operand-2 source: 00 reg, 01 zext data, 10 zext address, 11 sext data
//   register1/2     operand register indices; dest is the writeback index
//   data, address   immediate and address offset
//   gatealu, answer answer = gatealu ? RESULT : 0 (combinational)
//   done            one-cycle completion pulse
//   nzp             condition codes {N,Z,P}
//   sr1out, sr2out  combinational reads of R[register1] and R[register2]
module alu_seq #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NREG   = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 7,
    localparam int unsigned RW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              ready,
    input  logic [2:0]        aluk,
    input  logic [1:0]        sr2select,
    input  logic [RW-1:0]     register1,
    input  logic [RW-1:0]     register2,
    input  logic [RW-1:0]     dest,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] address,
    input  logic              gatealu,
    output logic [WIDTH-1:0]  answer,
    output logic              done,
    output logic [2:0]        nzp,
    output logic [WIDTH-1:0]  sr1out,
    output logic [WIDTH-1:0]  sr2out
);

    typedef enum logic [1:0] {StIdle, StExec, StMult} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [2:0]       aluk_q, aluk_d;
    logic [RW-1:0]    dest_q, dest_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       nzp_q, nzp_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] op2_sel;
    logic             wb_en;
    logic [WIDTH-1:0] wb_val;

`ifdef ALU_SEQ_MUL_EN
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mul_sum;
`endif

    // Operand-2 source; the size casts zero- or sign-extend as selected.
    always_comb begin
        op2_sel = '0;
        unique case (sr2select)
            2'b00: op2_sel = regs_q[register2];
            2'b01: op2_sel = WIDTH'(data);
            2'b10: op2_sel = WIDTH'(address);
            2'b11: op2_sel = WIDTH'($signed(data));
            default: op2_sel = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        regs_d   = regs_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        aluk_d   = aluk_q;
        dest_d   = dest_q;
        result_d = result_q;
        nzp_d    = nzp_q;
        done_d   = 1'b0;
        wb_en    = 1'b0;
        wb_val   = '0;
`ifdef ALU_SEQ_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mul_sum  = '0;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op1_d   = regs_q[register1];
                    op2_d   = op2_sel;
                    aluk_d  = aluk;
                    dest_d  = dest;
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StIdle;
                done_d  = 1'b1;
                case (aluk_q)
                    3'b000: begin wb_en = 1'b1; wb_val = op1_q + op2_q; end
                    3'b001: begin wb_en = 1'b1; wb_val = op1_q - op2_q; end
                    3'b010: begin wb_en = 1'b1; wb_val = op1_q & op2_q; end
                    3'b011: begin wb_en = 1'b1; wb_val = op1_q | op2_q; end
                    3'b100: begin wb_en = 1'b1; wb_val = op1_q ^ op2_q; end
                    3'b101: begin wb_en = 1'b1; wb_val = ~op1_q;         end
                    3'b110: begin wb_en = 1'b1; wb_val = op2_q;          end
                    default: begin
`ifdef ALU_SEQ_MUL_EN
                        done_d   = 1'b0;
                        mcand_d  = op1_q;
                        mplier_d = op2_q;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = StMult;
`endif
                        // Without the multiplier: done pulses, nothing else changes.
                    end
                endcase
            end
`ifdef ALU_SEQ_MUL_EN
            StMult: begin
                // Multiplicand shifts left as multiplier shifts right; bits above WIDTH
                // fall off, which yields the low half of the product.
                mul_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    wb_en   = 1'b1;
                    wb_val  = mul_sum;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        if (wb_en) begin
            regs_d[dest_q] = wb_val;
            result_d       = wb_val;
            nzp_d          = {wb_val[WIDTH-1], (wb_val == '0),
                              (!wb_val[WIDTH-1] && (wb_val != '0))};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            regs_q   <= '{default: '0};
            op1_q    <= '0;
            op2_q    <= '0;
            aluk_q   <= '0;
            dest_q   <= '0;
            result_q <= '0;
            nzp_q    <= 3'b010;
            done_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            regs_q   <= regs_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            aluk_q   <= aluk_d;
            dest_q   <= dest_d;
            result_q <= result_d;
            nzp_q    <= nzp_d;
            done_q   <= done_d;
`ifdef ALU_SEQ_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign ready  = (state_q == StIdle);
    assign done   = done_q;
    assign nzp    = nzp_q;
    assign answer = gatealu ? result_q : '0;
    assign sr1out = regs_q[register1];
    assign sr2out = regs_q[register2];

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          ready;
    logic [2:0]    aluk = '0;
    logic [1:0]    sr2select = '0;
    logic [2:0]    register1 = '0;
    logic [2:0]    register2 = '0;
    logic [2:0]    dest = '0;
    logic [7:0]    data = '0;
    logic [6:0]    address = '0;
    logic          gatealu = 1'b1;
    logic [W-1:0]  answer;
    logic          done;
    logic [2:0]    nzp;
    logic [W-1:0]  sr1out;
    logic [W-1:0]  sr2out;

    alu_seq #(.WIDTH(W), .NREG(8), .DATA_W(8), .ADDR_W(7)) dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready), .aluk(aluk),
        .sr2select(sr2select), .register1(register1), .register2(register2), .dest(dest),
        .data(data), .address(address), .gatealu(gatealu), .answer(answer), .done(done),
        .nzp(nzp), .sr1out(sr1out), .sr2out(sr2out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]   aluk;
        logic [1:0]   sel;
        logic [2:0]   r1;
        logic [2:0]   r2;
        logic [2:0]   dest;
        logic [7:0]   data;
        logic [6:0]   addr;
        logic [W-1:0] val;
        logic [2:0]   nzp;
    } vec_t;

    typedef struct {
        logic [W-1:0] ans;
        logic [2:0]   nzp;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] mregs[8];
    logic [W-1:0] last_res = '0;
    logic [2:0]   last_nzp = 3'b010;
    int           checks = 0;
    int           errors = 0;
    vec_t         tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Called just after a rising edge; waits for ready, then drives one request.
    task automatic issue(input vec_t v, input bit wr, input int lat);
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", 32'(ready), 1);
        aluk = v.aluk; sr2select = v.sel; register1 = v.r1; register2 = v.r2;
        dest = v.dest; data = v.data; address = v.addr;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sbq.push_back('{ans: (wr ? v.val : last_res), nzp: (wr ? v.nzp : last_nzp),
                        cyc: cyc + lat});
        if (wr) begin
            mregs[v.dest] = v.val;
            last_res      = v.val;
            last_nzp      = v.nzp;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || ready !== 1'b1) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_outstanding", 32'(sbq.size()), 0);
    endtask

    task automatic readback(input string tag);
        for (int i = 0; i < 8; i++) begin
            register1 = 3'(i);
            register2 = 3'(7 - i);
            #1;
            check({tag, "_sr1out"}, 32'(sr1out), 32'(mregs[i]));
            check({tag, "_sr2out"}, 32'(sr2out), 32'(mregs[7 - i]));
        end
    endtask

    // Scoreboard: every done pops one expected record.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: done=1 with no operation outstanding, required 0");
            end else begin
                e = sbq.pop_front();
                check("answer", 32'(answer), 32'(e.ans));
                check("nzp", 32'(nzp), 32'(e.nzp));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        vec_t v;
        for (int i = 0; i < 8; i++) mregs[i] = '0;

        //        aluk    sel    r1    r2    dest  data   addr   val       nzp
        tbl[0]  = '{3'd0, 2'b01, 3'd0, 3'd0, 3'd3, 8'h2A, 7'h00, 16'h002A, 3'b001};
        tbl[1]  = '{3'd1, 2'b00, 3'd0, 3'd3, 3'd4, 8'h00, 7'h00, 16'hFFD6, 3'b100};
        tbl[2]  = '{3'd0, 2'b11, 3'd3, 3'd0, 3'd3, 8'hFF, 7'h00, 16'h0029, 3'b001};
        tbl[3]  = '{3'd6, 2'b00, 3'd0, 3'd3, 3'd5, 8'h00, 7'h00, 16'h0029, 3'b001};
        tbl[4]  = '{3'd2, 2'b10, 3'd4, 3'd0, 3'd6, 8'h00, 7'h7F, 16'h0056, 3'b001};
        tbl[5]  = '{3'd3, 2'b00, 3'd3, 3'd4, 3'd1, 8'h00, 7'h00, 16'hFFFF, 3'b100};
        tbl[6]  = '{3'd4, 2'b00, 3'd1, 3'd1, 3'd2, 8'h00, 7'h00, 16'h0000, 3'b010};
        tbl[7]  = '{3'd5, 2'b00, 3'd2, 3'd0, 3'd7, 8'h00, 7'h00, 16'hFFFF, 3'b100};
        tbl[8]  = '{3'd1, 2'b00, 3'd5, 3'd3, 3'd0, 8'h00, 7'h00, 16'h0000, 3'b010};
        tbl[9]  = '{3'd6, 2'b11, 3'd0, 3'd0, 3'd2, 8'h80, 7'h00, 16'hFF80, 3'b100};
        tbl[10] = '{3'd0, 2'b00, 3'd1, 3'd1, 3'd1, 8'h00, 7'h00, 16'hFFFE, 3'b100};
        tbl[11] = '{3'd0, 2'b01, 3'd7, 3'd0, 3'd7, 8'h01, 7'h00, 16'h0000, 3'b010};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_ready", 32'(ready), 1);
        check("reset_done", 32'(done), 0);
        check("reset_nzp", 32'(nzp), 32'(3'b010));
        check("reset_answer", 32'(answer), 0);
        readback("reset");

        // Back-to-back table: each request issues in the previous op's done cycle.
        for (int i = 0; i < 12; i++) issue(tbl[i], 1'b1, 1);
        drain();

        // A second start held during EXEC must be ignored.
        issue('{3'd6, 2'b01, 3'd0, 3'd0, 3'd6, 8'h33, 7'h00, 16'h0033, 3'b001}, 1'b1, 1);
        aluk = 3'd6; sr2select = 2'b01; dest = 3'd2; data = 8'h77; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain();

        gatealu = 1'b0;
        #1 check("gate_off_answer", 32'(answer), 0);
        gatealu = 1'b1;
        #1 check("gate_on_answer", 32'(answer), 32'h0033);

`ifdef ALU_SEQ_MUL_EN
        issue('{3'd6, 2'b01, 3'd0, 3'd0, 3'd1, 8'h07, 7'h00, 16'h0007, 3'b001}, 1'b1, 1);
        issue('{3'd6, 2'b01, 3'd0, 3'd0, 3'd2, 8'h06, 7'h00, 16'h0006, 3'b001}, 1'b1, 1);
        issue('{3'd7, 2'b00, 3'd1, 3'd2, 3'd3, 8'h00, 7'h00, 16'h002A, 3'b001}, 1'b1, W + 1);
        // Starts pulsed mid-MULT must be ignored.
        @(posedge clk); #1;
        aluk = 3'd6; sr2select = 2'b01; dest = 3'd5; data = 8'h55; start = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b0;
        issue('{3'd6, 2'b01, 3'd0, 3'd0, 3'd1, 8'hFF, 7'h00, 16'h00FF, 3'b001}, 1'b1, 1);
        issue('{3'd0, 2'b01, 3'd1, 3'd0, 3'd1, 8'h01, 7'h00, 16'h0100, 3'b001}, 1'b1, 1);
        issue('{3'd7, 2'b00, 3'd1, 3'd1, 3'd4, 8'h00, 7'h00, 16'h0000, 3'b010}, 1'b1, W + 1);
`else
        // Without the multiplier: done at T+1, R3/RESULT/NZP unchanged.
        issue('{3'd7, 2'b00, 3'd1, 3'd2, 3'd3, 8'h00, 7'h00, 16'h0000, 3'b000}, 1'b0, 1);
`endif
        drain();
        readback("final");

        // Reset in the middle of an operation: no writeback, everything back to reset.
        sbq.delete();
        aluk = 3'd0; sr2select = 2'b01; register1 = 3'd6; dest = 3'd0; data = 8'h10;
`ifdef ALU_SEQ_MUL_EN
        aluk = 3'd7; sr2select = 2'b00; register2 = 3'd6;
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        repeat (3) begin @(posedge clk); #1; end
`endif
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midop_reset_ready", 32'(ready), 1);
        check("midop_reset_nzp", 32'(nzp), 32'(3'b010));
        check("midop_reset_done", 32'(done), 0);
        check("midop_reset_answer", 32'(answer), 0);
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        readback("midop_reset");
        repeat (W + 4) begin
            @(posedge clk); #1;
        end
        check("midop_reset_no_late_write", 32'(dut.sr1out), 32'(mregs[register1]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
